// File: rtl/apb_coeff_bank.sv
// APB-programmable coefficient bank: software writes a shadow copy, then a commit
// copies selected channels into the active set one tap per cycle.
module apb_coeff_bank #(
    parameter int ADDR_WIDTH  = 12,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  PSEL,
    input  logic                                  PENABLE,
    input  logic                                  PWRITE,
    input  logic [ADDR_WIDTH-1:0]                 PADDR,
    input  logic [PDATA_WIDTH-1:0]                PWDATA,
    output logic [PDATA_WIDTH-1:0]                PRDATA,
    output logic                                  PREADY,
    output logic                                  PSLVERR,
    output logic [NUM_CH*DEPTH*COEFF_WIDTH-1:0]   coeff_active,
    output logic [NUM_CH-1:0]                     coeff_vld,
    output logic                                  busy
);

    localparam int NC      = NUM_CH * DEPTH;
    localparam int IW      = ADDR_WIDTH - 2;
    localparam int KW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int SH_BASE = 16;

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_e;

    state_e                         state_q, state_d;
    logic [KW-1:0]                  k_q, k_d;
    logic [NUM_CH-1:0]              mask_q, mask_d;
    logic [NC-1:0][COEFF_WIDTH-1:0] shadow_q, shadow_d;
    logic [NC-1:0][COEFF_WIDTH-1:0] active_q, active_d;
    logic [WW-1:0]                  wait_q, wait_d;
    logic                           err_q, err_d;
    logic [IW-1:0]                  err_addr_q, err_addr_d;

    logic [IW-1:0]          widx;
    logic [31:0]            idx;
    logic                   is_ctrl, is_stat, is_eaddr, is_sh;
    logic [NUM_CH-1:0]      hit_ch;
    logic [COEFF_WIDTH-1:0] sh_rd;
    logic                   access, wait_done, stall, ready, commit_wr, err, commit_go;
    logic [PDATA_WIDTH-1:0] status, rdata;
    logic                   unused_bits;

    assign unused_bits = ^{PADDR[1:0], PWDATA};

    assign widx     = PADDR[ADDR_WIDTH-1:2];
    assign idx      = 32'(widx);
    assign is_ctrl  = (idx == 32'd0);
    assign is_stat  = (idx == 32'd1);
    assign is_eaddr = (idx == 32'd2);
    assign is_sh    = (idx >= 32'(SH_BASE)) && (idx < 32'(SH_BASE + NC));

    always_comb begin
        hit_ch = '0;
        sh_rd  = '0;
        for (int c = 0; c < NUM_CH; c++)
            hit_ch[c] = (idx >= 32'(SH_BASE + c*DEPTH)) && (idx < 32'(SH_BASE + (c+1)*DEPTH));
        for (int i = 0; i < NC; i++)
            if (idx == 32'(SH_BASE + i)) sh_rd = shadow_q[i];
    end

    // Only writes into channels being copied must wait; everything else flows through.
    assign access    = PSEL & PENABLE;
    assign wait_done = (wait_q == WW'(WAIT_STATES));
    assign stall     = busy & PWRITE & |(hit_ch & mask_q);
    assign ready     = rst_n & access & wait_done & ~stall;
    assign commit_wr = PWRITE & is_ctrl & PWDATA[0];
    assign err       = ~(is_ctrl | is_stat | is_eaddr | is_sh)
                     | (PWRITE & (is_stat | is_eaddr))
                     | (~PWRITE & is_ctrl)
                     | (commit_wr & busy);
    assign commit_go = ready & commit_wr & ~busy & |PWDATA[NUM_CH+7:8];

    always_comb begin
        wait_d = wait_q;
        if (!access || ready) wait_d = '0;
        else if (!wait_done)  wait_d = wait_q + 1'b1;
    end

    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (ready && PWRITE && is_sh)
            for (int i = 0; i < NC; i++)
                if (idx == 32'(SH_BASE + i)) shadow_d[i] = PWDATA[COEFF_WIDTH-1:0];
        if (state_q == S_COPY)
            for (int c = 0; c < NUM_CH; c++)
                for (int t = 0; t < DEPTH; t++)
                    if (mask_q[c] && k_q == KW'(t)) active_d[c*DEPTH+t] = shadow_q[c*DEPTH+t];
        if (ready && err) begin
            err_d      = 1'b1;
            err_addr_d = widx;
        end else if (ready && !PWRITE && is_stat) begin
            err_d      = 1'b0;
        end
    end

    always_comb begin
        status               = '0;
        status[0]            = busy;
        status[1]            = err_q;
        status[NUM_CH+7:8]   = mask_q;
        rdata                = '0;
        if (is_stat)         rdata = status;
        else if (is_eaddr)   rdata = PDATA_WIDTH'(err_addr_q);
        else if (is_sh)      rdata = PDATA_WIDTH'($signed(sh_rd));
    end

    assign PREADY       = ready;
    assign PSLVERR      = ready & err;
    assign PRDATA       = (ready && !PWRITE && !err) ? rdata : '0;
    assign coeff_active = active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: if (commit_go) begin
                state_d = S_COPY;
                k_d     = '0;
                mask_d  = PWDATA[NUM_CH+7:8];
            end
            S_COPY: if (k_q == KW'(DEPTH-1)) state_d = S_DONE;
                    else                      k_d     = k_q + 1'b1;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        coeff_vld = (state_q == S_DONE) ? mask_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            active_q   <= '0;
            wait_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            wait_q     <= wait_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

endmodule
